// File: rtl/md_scheduler.sv
// Multi-cycle mult/div scheduler owning the architectural HI/LO registers.
// Optional MDS_DIV_ZERO_SKIP_EN: divide-by-zero completes after a single busy cycle.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDS_i_E_Start,
    input  logic [1:0]  MDS_i_E_Op,
    input  logic [31:0] MDS_i_E_A,
    input  logic [31:0] MDS_i_E_B,
    input  logic [1:0]  MDS_i_E_HiLoWrite,
    input  logic        MDS_i_D_UsesMD,
    output logic        MDS_o_Busy,
    output logic        MDS_o_Stall,
    output logic [31:0] MDS_o_HI,
    output logic [31:0] MDS_o_LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic               b_zero;
    logic [31:0]        divisor;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;

    // Arithmetic datapath works on the latched operands; divisor forced to 1 when zero to stay X-free.
    assign a_sx    = {{32{a_q[31]}}, a_q};
    assign b_sx    = {{32{b_q[31]}}, b_q};
    assign prod_s  = a_sx * b_sx;
    assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
    assign b_zero  = (b_q == 32'd0);
    assign divisor = b_zero ? 32'd1 : b_q;
    assign quo_s   = $signed(a_q) / $signed(divisor);
    assign rem_s   = $signed(a_q) % $signed(divisor);
    assign quo_u   = a_q / divisor;
    assign rem_u   = a_q % divisor;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == S_IDLE) begin
            if (MDS_i_E_Start) begin
                a_d     = MDS_i_E_A;
                b_d     = MDS_i_E_B;
                op_d    = MDS_i_E_Op;
                state_d = S_BUSY;
                cnt_d   = MDS_i_E_Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`ifdef MDS_DIV_ZERO_SKIP_EN
                if (MDS_i_E_Op[1] && (MDS_i_E_B == 32'd0)) begin
                    cnt_d = CNT_W'(1);
                end
`endif
            end else begin
                if (MDS_i_E_HiLoWrite[1]) hi_d = MDS_i_E_A;
                if (MDS_i_E_HiLoWrite[0]) lo_d = MDS_i_E_A;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (op_q == OP_MULT) begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end else if (op_q == OP_MULTU) begin
                    hi_d = prod_u[63:32];
                    lo_d = prod_u[31:0];
                end else if (!b_zero) begin
                    hi_d = (op_q == OP_DIV) ? 32'(rem_s) : rem_u;
                    lo_d = (op_q == OP_DIV) ? 32'(quo_s) : quo_u;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign MDS_o_Busy  = (state_q == S_BUSY);
    // Hazard request must be seen in the Start cycle itself, hence combinational.
    assign MDS_o_Stall = MDS_i_D_UsesMD & (MDS_i_E_Start | MDS_o_Busy);
    assign MDS_o_HI    = hi_q;
    assign MDS_o_LO    = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler with a HI/LO scoreboard popped on operation completion.
module tb_md_scheduler;

`ifdef MDS_DIV_ZERO_SKIP_EN
    localparam int DZ_CYC = 1;
`else
    localparam int DZ_CYC = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [1:0]  hlw;
    logic        uses;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] hi_m, lo_m;
    logic [63:0] sb_q[$];

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk               (clk),
        .reset             (rst_n),
        .MDS_i_E_Start     (start),
        .MDS_i_E_Op        (op),
        .MDS_i_E_A         (a),
        .MDS_i_E_B         (b),
        .MDS_i_E_HiLoWrite (hlw),
        .MDS_i_D_UsesMD    (uses),
        .MDS_o_Busy        (busy),
        .MDS_o_Stall       (stall),
        .MDS_o_HI          (hi),
        .MDS_o_LO          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the current negedge and follow it to completion.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic u, input logic [1:0] hlw_start,
                          input logic [1:0] hlw_busy, input logic [31:0] busy_a,
                          input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [63:0] e;
        sb_q.push_back({exp_hi, exp_lo});
        start = 1'b1; op = o; a = ia; b = ib; uses = u; hlw = hlw_start;
        #1 check({tag, " stall@start"}, 64'(stall), 64'(u));
        @(negedge clk);
        start = 1'b0; hlw = hlw_busy; a = busy_a;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            check({tag, " stall@busy"}, 64'(stall), 64'(u));
            @(negedge clk);
            hlw = 2'b00;
        end
        hlw = 2'b00;
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_cyc));
        check({tag, " stall@done"}, 64'(stall), 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " hi_lo"}, {hi, lo}, e);
            hi_m = e[63:32];
            lo_m = e[31:0];
        end
        uses = 1'b0;
    endtask

    task automatic hl_write(input string tag, input logic [1:0] w, input logic [31:0] val);
        hlw = w; a = val;
        @(negedge clk);
        hlw = 2'b00;
        if (w[1]) hi_m = val;
        if (w[0]) lo_m = val;
        check({tag, " hi_lo"}, {hi, lo}, {hi_m, lo_m});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; hlw = 2'b00; uses = 1'b1;
        hi_m = '0; lo_m = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset hi_lo", {hi, lo}, 64'd0);
        rst_n = 1'b1; uses = 1'b0;
        @(negedge clk);

        run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1, 2'b00, 2'b00, 32'd0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 2'b00, 2'b00, 32'd0, 5, 32'd2, 32'hFFFF_FFFA);
        run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 2'b00, 2'b00, 32'd0, 10, 32'd2, 32'd14);
        run_op("div_neg_a", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 2'b00, 2'b00, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_neg_b", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 2'b00, 2'b00, 32'd0, 10, 32'd1, 32'hFFFF_FFFD);

        hl_write("mthi", 2'b10, 32'h0000_1234);
        hl_write("mthi5", 2'b10, 32'd5);
        hl_write("mtlo6", 2'b01, 32'd6);

        // Divide by zero also carries a same-cycle mthi/mtlo and a busy-time mtlo, all of which must drop.
        run_op("div_zero", 2'b10, 32'h0000_DEAD, 32'd0, 1'b1, 2'b11, 2'b01, 32'h0000_BEEF, DZ_CYC, hi_m, lo_m);
        run_op("divu_zero", 2'b11, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b10, 32'h0000_CAFE, DZ_CYC, hi_m, lo_m);

        // Reset in the third busy cycle of a divide.
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi_lo", {hi, lo}, 64'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_abort busy", 64'(busy), 64'd0);
        check("post_abort hi_lo", {hi, lo}, 64'd0);

        // Start presented together with reset release is taken on the first edge.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mult_after_reset", 2'b00, 32'd7, 32'd6, 1'b0, 2'b00, 2'b00, 32'd0, 5, 32'd0, 32'd42);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MDS_i_E_Start  input  1  E-stage holds mult/multu/div/divu this cycle.
REQ-006 SHALL have port MDS_i_E_Op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port MDS_i_E_A  input  32  rs operand, forwarded.
REQ-008 SHALL have port MDS_i_E_B  input  32  rt operand, forwarded.
REQ-009 SHALL have port MDS_i_E_HiLoWrite  input  2  bit1 mthi, bit0 mtlo, from E-stage.
REQ-010 SHALL have port MDS_i_D_UsesMD  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port MDS_o_Busy  output  1  operation in progress.
REQ-012 SHALL have port MDS_o_Stall  output  1  stall request to hazard unit.
REQ-013 SHALL have port MDS_o_HI  output  32  architectural HI.
REQ-014 SHALL have port MDS_o_LO  output  32  architectural LO.

Function
REQ-015 SHALL implement two states, IDLE and BUSY, plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 In IDLE, on MDS_i_E_Start, SHALL latch A, B and Op, load counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY at the next edge.
REQ-017 In BUSY, SHALL decrement counter each cycle; at the edge where counter equals 1, SHALL write results to HI/LO and return to IDLE.
REQ-018 Latency: Start sampled at edge t; MDS_o_Busy high for cycles t+1..t+N; new HI/LO visible from cycle t+N+1, where N is the op's cycle count.
REQ-019 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-020 div: LO = signed quotient truncated toward zero, HI = remainder with sign of A; divu: unsigned quotient/remainder.
REQ-021 Division with B == 0 SHALL leave HI and LO unchanged.
REQ-022 mthi/mtlo SHALL write A into HI/LO at the next edge, only in IDLE and only when MDS_i_E_Start is low.
REQ-023 If MDS_i_E_Start and MDS_i_E_HiLoWrite are both active, Start SHALL win and the write SHALL be dropped.
REQ-024 MDS_i_E_Start and MDS_i_E_HiLoWrite SHALL be ignored in BUSY.
REQ-025 MDS_o_Busy SHALL be high exactly while in BUSY.
REQ-026 MDS_o_Stall SHALL be combinational: MDS_i_D_UsesMD AND (MDS_i_E_Start OR MDS_o_Busy).
REQ-027 MDS_o_HI/MDS_o_LO SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-028 On reset low, SHALL immediately force IDLE, counter 0, HI = 0, LO = 0, latched operands 0, and MDS_o_Busy = 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation; no HI/LO write occurs.
REQ-030 After reset release, the first rising edge SHALL accept a Start.

Configuration
REQ-031 Macro MDS_DIV_ZERO_SKIP_EN: when defined, div/divu with B == 0 SHALL complete in 1 busy cycle with HI/LO unchanged.
REQ-032 When MDS_DIV_ZERO_SKIP_EN is undefined, div/divu with B == 0 SHALL occupy the full DIV_CYCLES with HI/LO unchanged.

Verification
REQ-033 Bench SHALL cover mult with A=0xFFFFFFFE, B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 Bench SHALL cover divu with A=100, B=7 -> Busy high 10 cycles; then LO=14, HI=2; div with A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 Bench SHALL cover MDS_i_D_UsesMD=1 held during a mult -> Stall high from the Start cycle through the last Busy cycle, low on the cycle HI/LO update.
REQ-036 Bench SHALL cover Start plus mthi in the same cycle, and mtlo while BUSY -> both writes dropped; mthi A=0x1234 in IDLE -> HI=0x1234 next cycle.
REQ-037 Bench SHALL cover reset pulsed low in busy cycle 3 of a div -> Busy=0 immediately, HI=LO=0, no later write.
REQ-038 Bench SHALL cover div with B=0 and HI=5, LO=6 -> HI/LO stay 5/6; Busy lasts 1 cycle with MDS_DIV_ZERO_SKIP_EN, 10 cycles without.
